// File: rtl/ddr4_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// ddr4_cmd_scheduler_if : request side and DDR4 command/address side signals
// Rev 1.0
// ============================================================================
interface ddr4_cmd_scheduler_if #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10
);
  localparam int NBANK = 2**(BGWIDTH+BAWIDTH);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [BGWIDTH-1:0]   req_bg;
  logic [BAWIDTH-1:0]   req_ba;
  logic [ADDRWIDTH-1:0] req_row;
  logic [COLWIDTH-1:0]  req_col;

  logic                 cs_n;
  logic                 act_n;
  logic [ADDRWIDTH-1:0] A;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;
  logic                 writing;
  logic                 rd_valid;
  logic [NBANK-1:0]     bank_open;

  // Traffic source side
  modport master (
    output req_valid, req_wr, req_bg, req_ba, req_row, req_col,
    input  req_ready, cs_n, act_n, A, bg, ba, writing, rd_valid, bank_open
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_wr, req_bg, req_ba, req_row, req_col,
    output req_ready, cs_n, act_n, A, bg, ba, writing, rd_valid, bank_open
  );
endinterface
`default_nettype wire

// File: rtl/ddr4_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// ddr4_cmd_scheduler : single-rank DDR4 PRE/ACT/CAS sequencer with open-row table
// Rev 1.0
// ============================================================================
module ddr4_cmd_scheduler #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRCD      = 15,
  parameter int TRP       = 15,
  parameter int TCL       = 10
) (
  input  logic                ck_t,
  input  logic                reset,
  ddr4_cmd_scheduler_if.slave bus
);
  localparam int NBANK = 2**(BGWIDTH+BAWIDTH);
  localparam int IDXW  = BGWIDTH + BAWIDTH;
  localparam int M1    = (TRP > TRCD) ? TRP : TRCD;
  localparam int M2    = (TCL > BL) ? TCL : BL;
  localparam int CMAX  = (M1 > M2) ? M1 : M2;
  localparam int CNTW  = $clog2(CMAX + 1);

  // A[16:14] carry RAS_n/CAS_n/WE_n; upper bits beyond 16 stay zero
  localparam logic [ADDRWIDTH-1:0] A_NOP = ADDRWIDTH'(17'h1C000);
  localparam logic [ADDRWIDTH-1:0] A_PRE = ADDRWIDTH'(17'h08000);
  localparam logic [ADDRWIDTH-1:0] A_WR  = ADDRWIDTH'(17'h10000);
  localparam logic [ADDRWIDTH-1:0] A_RD  = ADDRWIDTH'(17'h14000);

  localparam logic [CNTW-1:0] CNT_RP  = CNTW'(TRP - 1);
  localparam logic [CNTW-1:0] CNT_RCD = CNTW'(TRCD - 1);
  localparam logic [CNTW-1:0] CNT_CL  = CNTW'(TCL - 1);
  localparam logic [CNTW-1:0] CNT_BL  = CNTW'(BL - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE      = 3'd1,
    S_WAIT_RP  = 3'd2,
    S_ACT      = 3'd3,
    S_WAIT_RCD = 3'd4,
    S_CAS      = 3'd5,
    S_WAIT_CL  = 3'd6,
    S_BURST    = 3'd7
  } state_t;

  state_t               state;
  logic [CNTW-1:0]      cnt;

  logic                 lat_wr;
  logic [BGWIDTH-1:0]   lat_bg;
  logic [BAWIDTH-1:0]   lat_ba;
  logic [ADDRWIDTH-1:0] lat_row;
  logic [COLWIDTH-1:0]  lat_col;

  logic                 cmd_cs_n;
  logic                 cmd_act_n;
  logic [ADDRWIDTH-1:0] cmd_a;
  logic [BGWIDTH-1:0]   cmd_bg;
  logic [BAWIDTH-1:0]   cmd_ba;
  logic                 win_wr;
  logic                 win_rd;
  logic [NBANK-1:0]     open_flag;
  logic [ADDRWIDTH-1:0] open_row [NBANK];

  logic                 accept;
  logic                 sel_wr;
  logic [BGWIDTH-1:0]   sel_bg;
  logic [BAWIDTH-1:0]   sel_ba;
  logic [ADDRWIDTH-1:0] sel_row;
  logic [COLWIDTH-1:0]  sel_col;
  logic [IDXW-1:0]      sel_idx;
  logic                 sel_open;
  logic                 sel_hit;
  logic [ADDRWIDTH-1:0] sel_cas_a;

  assign bus.req_ready = (state == S_IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // In IDLE the command is built straight from the request; afterwards from the latched copy
  always_comb begin
    sel_wr  = lat_wr;
    sel_bg  = lat_bg;
    sel_ba  = lat_ba;
    sel_row = lat_row;
    sel_col = lat_col;
    if (state == S_IDLE) begin
      sel_wr  = bus.req_wr;
      sel_bg  = bus.req_bg;
      sel_ba  = bus.req_ba;
      sel_row = bus.req_row;
      sel_col = bus.req_col;
    end
  end

  assign sel_idx   = {sel_bg, sel_ba};
  assign sel_open  = open_flag[sel_idx];
  assign sel_hit   = sel_open && (open_row[sel_idx] == sel_row);
  assign sel_cas_a = (sel_wr ? A_WR : A_RD) | ADDRWIDTH'(sel_col);

  always_ff @(posedge ck_t or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_bg    <= '0;
      lat_ba    <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
      cmd_cs_n  <= 1'b1;
      cmd_act_n <= 1'b1;
      cmd_a     <= A_NOP;
      cmd_bg    <= '0;
      cmd_ba    <= '0;
      win_wr    <= 1'b0;
      win_rd    <= 1'b0;
      open_flag <= '0;
      for (int i = 0; i < NBANK; i++) open_row[i] <= '0;
    end else begin
      cmd_cs_n  <= 1'b1;
      cmd_act_n <= 1'b1;
      cmd_a     <= A_NOP;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            lat_wr   <= bus.req_wr;
            lat_bg   <= bus.req_bg;
            lat_ba   <= bus.req_ba;
            lat_row  <= bus.req_row;
            lat_col  <= bus.req_col;
            cmd_cs_n <= 1'b0;
            cmd_bg   <= sel_bg;
            cmd_ba   <= sel_ba;
            if (sel_hit) begin
              cmd_a <= sel_cas_a;
              cnt   <= CNT_CL;
              state <= S_CAS;
            end else if (sel_open) begin
              cmd_a              <= A_PRE;
              open_flag[sel_idx] <= 1'b0;
              cnt                <= CNT_RP;
              state              <= S_PRE;
            end else begin
              cmd_act_n          <= 1'b0;
              cmd_a              <= sel_row;
              open_flag[sel_idx] <= 1'b1;
              open_row[sel_idx]  <= sel_row;
              cnt                <= CNT_RCD;
              state              <= S_ACT;
            end
          end
        end
        S_PRE, S_WAIT_RP: begin
          if (cnt == '0) begin
            cmd_cs_n           <= 1'b0;
            cmd_act_n          <= 1'b0;
            cmd_a              <= sel_row;
            cmd_bg             <= sel_bg;
            cmd_ba             <= sel_ba;
            open_flag[sel_idx] <= 1'b1;
            open_row[sel_idx]  <= sel_row;
            cnt                <= CNT_RCD;
            state              <= S_ACT;
          end else begin
            cnt   <= cnt - 1'b1;
            state <= S_WAIT_RP;
          end
        end
        S_ACT, S_WAIT_RCD: begin
          if (cnt == '0) begin
            cmd_cs_n <= 1'b0;
            cmd_a    <= sel_cas_a;
            cmd_bg   <= sel_bg;
            cmd_ba   <= sel_ba;
            cnt      <= CNT_CL;
            state    <= S_CAS;
          end else begin
            cnt   <= cnt - 1'b1;
            state <= S_WAIT_RCD;
          end
        end
        S_CAS, S_WAIT_CL: begin
          if (cnt == '0) begin
            win_wr <= lat_wr;
            win_rd <= !lat_wr;
            cnt    <= CNT_BL;
            state  <= S_BURST;
          end else begin
            cnt   <= cnt - 1'b1;
            state <= S_WAIT_CL;
          end
        end
        S_BURST: begin
          if (cnt == '0) begin
            win_wr <= 1'b0;
            win_rd <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cs_n      = cmd_cs_n;
  assign bus.act_n     = cmd_act_n;
  assign bus.A         = cmd_a;
  assign bus.bg        = cmd_bg;
  assign bus.ba        = cmd_ba;
  assign bus.writing   = win_wr;
  assign bus.rd_valid  = win_rd;
  assign bus.bank_open = open_flag;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// tb_ddr4_cmd_scheduler : directed scoreboard bench for ddr4_cmd_scheduler
// Rev 1.0
// ============================================================================
module tb_ddr4_cmd_scheduler;
  localparam int TRP  = 15;
  localparam int TRCD = 15;
  localparam int TCL  = 10;
  localparam int BL   = 8;

  logic ck_t  = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 ck_t = ~ck_t;
  always @(posedge ck_t) cyc <= cyc + 1;

  ddr4_cmd_scheduler_if #(.BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10)) bus ();

  ddr4_cmd_scheduler #(
    .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10),
    .BL(BL), .TRCD(TRCD), .TRP(TRP), .TCL(TCL)
  ) dut (
    .ck_t  (ck_t),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic        act_n;
    logic [16:0] a;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [15:0] bo;
  } ev_t;

  ev_t         q[$];
  logic [15:0] m_open = '0;
  logic [16:0] m_row [16];
  int          win_lo = 1;
  int          win_hi = 0;
  bit          win_is_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each command cycle pops the next predicted command
  always @(negedge ck_t) begin
    ev_t e;
    bit  in_win;
    if (bus.cs_n === 1'b0) begin
      if (q.size() == 0) begin
        check("unexpected_cmd_cs_n", {31'd0, bus.cs_n}, 32'd1);
      end else begin
        e = q.pop_front();
        check("cmd_cycle", cyc, e.cyc);
        check("cmd_act_n", {31'd0, bus.act_n}, {31'd0, e.act_n});
        check("cmd_A", {15'd0, bus.A}, {15'd0, e.a});
        check("cmd_bg", {30'd0, bus.bg}, {30'd0, e.bg});
        check("cmd_ba", {30'd0, bus.ba}, {30'd0, e.ba});
        check("cmd_bank_open", {16'd0, bus.bank_open}, {16'd0, e.bo});
      end
    end
    in_win = (cyc >= win_lo) && (cyc <= win_hi);
    check("writing", {31'd0, bus.writing}, {31'd0, in_win && win_is_wr});
    check("rd_valid", {31'd0, bus.rd_valid}, {31'd0, in_win && !win_is_wr});
  end

  task automatic push_ev(input int c, input logic an, input logic [16:0] a,
                         input logic [1:0] bgv, input logic [1:0] bav);
    ev_t e;
    e.cyc = c; e.act_n = an; e.a = a; e.bg = bgv; e.ba = bav; e.bo = m_open;
    q.push_back(e);
  endtask

  // Drives one request, predicts its command sequence, returns accept and ready cycles
  task automatic send(input bit wr, input logic [1:0] bgv, input logic [1:0] bav,
                      input logic [16:0] row, input logic [9:0] col,
                      output int t, output int rdy);
    int n = 0;
    int idx;
    int c;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_bg    = bgv;
    bus.req_ba    = bav;
    bus.req_row   = row;
    bus.req_col   = col;
    while (!bus.req_ready && n < 200) begin
      @(negedge ck_t);
      n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      t = cyc;
      rdy = cyc;
      return;
    end
    t   = cyc;
    idx = {bgv, bav};
    c   = t + 1;
    if (m_open[idx] && m_row[idx] != row) begin
      m_open[idx] = 1'b0;
      push_ev(c, 1'b1, 17'h08000, bgv, bav);
      c += TRP;
    end
    if (!m_open[idx]) begin
      m_open[idx] = 1'b1;
      m_row[idx]  = row;
      push_ev(c, 1'b0, row, bgv, bav);
      c += TRCD;
    end
    push_ev(c, 1'b1, (wr ? 17'h10000 : 17'h14000) | {7'd0, col}, bgv, bav);
    win_lo    = c + TCL;
    win_hi    = c + TCL + BL - 1;
    win_is_wr = wr;
    rdy       = c + TCL + BL;
    @(posedge ck_t);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int exp_cyc);
    for (int n = 0; n < 200; n++) begin
      @(negedge ck_t);
      if (bus.req_ready) begin
        check("ready_cycle", cyc, exp_cyc);
        check("events_left", q.size(), 32'd0);
        return;
      end
    end
    check("ready_timeout", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int t, r, t2, r2;
    for (int i = 0; i < 16; i++) m_row[i] = '0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_bg    = '0;
    bus.req_ba    = '0;
    bus.req_row   = '0;
    bus.req_col   = '0;

    repeat (3) @(posedge ck_t);
    @(negedge ck_t);
    check("rst_cs_n", {31'd0, bus.cs_n}, 32'd1);
    check("rst_act_n", {31'd0, bus.act_n}, 32'd1);
    check("rst_A", {15'd0, bus.A}, 32'h1C000);
    check("rst_bank_open", {16'd0, bus.bank_open}, 32'd0);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge ck_t);
    #1 reset = 1'b0;
    @(negedge ck_t);
    check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    // Closed bank write, hit read, miss read
    send(1'b1, 2'd1, 2'd1, 17'd1, 10'd2, t, r);
    check("s1_ready_lat", r - t, 32'd34);
    wait_idle(r);
    check("s1_bank5_open", {31'd0, bus.bank_open[5]}, 32'd1);
    send(1'b0, 2'd1, 2'd1, 17'd1, 10'd2, t, r);
    wait_idle(r);
    send(1'b0, 2'd1, 2'd1, 17'd4, 10'd0, t, r);
    wait_idle(r);

    // Access to a different closed bank leaves bank 5 open
    send(1'b1, 2'd0, 2'd2, 17'd7, 10'd5, t, r);
    wait_idle(r);
    check("s4_bank_open", {16'd0, bus.bank_open}, 32'h0024);

    // Reset while waiting out tRCD
    send(1'b0, 2'd3, 2'd3, 17'd3, 10'd1, t, r);
    repeat (4) @(posedge ck_t);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_cs_n", {31'd0, bus.cs_n}, 32'd1);
    check("mid_rst_act_n", {31'd0, bus.act_n}, 32'd1);
    check("mid_rst_A", {15'd0, bus.A}, 32'h1C000);
    check("mid_rst_bg", {30'd0, bus.bg}, 32'd0);
    check("mid_rst_ba", {30'd0, bus.ba}, 32'd0);
    check("mid_rst_bank_open", {16'd0, bus.bank_open}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    q.delete();
    m_open = '0;
    win_lo = 1;
    win_hi = 0;
    @(posedge ck_t);
    #1 reset = 1'b0;
    send(1'b0, 2'd1, 2'd1, 17'd4, 10'd0, t, r);
    wait_idle(r);

    // Request held pending while busy is taken in the first idle cycle
    send(1'b1, 2'd0, 2'd1, 17'd5, 10'd3, t, r);
    send(1'b1, 2'd2, 2'd0, 17'h1ABCD, 10'h3FF, t2, r2);
    check("s6_accept_cycle", t2, r);
    check("s6_ready_lat", r2 - t2, 32'd34);
    wait_idle(r2);
    check("s6_bank_open", {16'd0, bus.bank_open}, 32'h0122);

    repeat (3) @(negedge ck_t);
    check("final_events_left", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
